bus2st_lane_sched: RTL

- Packet-granular scheduler that shares one incoming memory read bus between NUM_LANES bus2st lanes, each feeding its own turbo decoder.
- Grants a whole turbo packet (NUM_BUS_PER_TURBO_PKT beats) to one idle lane, chosen round-robin.
- Forwards the beats to that lane, then marks the lane busy until the lane reports read-complete.
- Sits in the clk_bus domain between the memory read engine and the bus2st instances.

---
 rtl/bus2st_lane_sched.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/bus2st_lane_sched.sv
// bus2st_lane_sched
// Shares one memory read bus between NUM_LANES bus2st lanes in the clk_bus
// domain. A whole turbo packet (NUM_BUS_PER_TURBO_PKT beats) is granted to one
// idle lane, chosen round-robin, and the lane stays busy until it reports
// read-complete.
//
// Optional build macro: BUS2ST_SCHED_PKT_CNT_EN
//   defined   -> pkt_cnt counts dispatched packets (16-bit, wrapping)
//   undefined -> pkt_cnt is tied to 16'h0000 and no counter flops exist
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | searching for an eligible lane (ready and not busy), in_ready=0
// GRANT  | lane selection registered, beat counter cleared, in_ready=0
// STREAM | accepting beats for the granted lane until the packet is full
// CLOSE  | packet done: mark lane busy, advance round-robin pointer

module bus2st_lane_sched #(
    parameter int NUM_LANES             = 4,
    parameter int BUS                   = 534,
    parameter int NUM_BUS_PER_TURBO_PKT = 25
) (
    input  logic                 clk_bus,
    input  logic                 rst,
    input  logic [BUS-1:0]       in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BUS-1:0]       lane_data,
    output logic [NUM_LANES-1:0] lane_en,
    input  logic [NUM_LANES-1:0] lane_ready,
    input  logic [NUM_LANES-1:0] lane_complt,
    output logic [2:0]           cur_lane,
    output logic [NUM_LANES-1:0] lane_busy,
    output logic [15:0]          pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        STREAM = 2'd2,
        CLOSE  = 2'd3
    } state_t;

    localparam logic [7:0] PKT_BEATS = 8'(NUM_BUS_PER_TURBO_PKT);
    localparam logic [7:0] LAST_BEAT = 8'(NUM_BUS_PER_TURBO_PKT - 1);
    localparam logic [3:0] LANES_W4  = 4'(NUM_LANES);

    state_t               state;
    state_t               state_nxt;
    logic [7:0]           beat_cnt;
    logic [2:0]           rr_ptr;
    logic [NUM_LANES-1:0] complt_q;
    logic [NUM_LANES-1:0] complt_rise;
    logic [NUM_LANES-1:0] elig;
    logic [NUM_LANES-1:0] elig_rot;
    logic [NUM_LANES-1:0] cur_onehot;
    logic [NUM_LANES-1:0] busy_set;
    logic                 sel_found;
    logic [2:0]           sel_idx;
    logic                 xfer;

    assign elig        = lane_ready & ~lane_busy;
    assign complt_rise = lane_complt & ~complt_q;
    assign cur_onehot  = NUM_LANES'(1) << cur_lane;
    assign xfer        = in_valid & in_ready;
    assign busy_set    = (state == CLOSE) ? cur_onehot : '0;

    // Rotate eligibility so bit 0 corresponds to rr_ptr; the lowest set bit
    // of the rotated vector is then the first eligible lane at or after rr_ptr.
    assign elig_rot = NUM_LANES'({elig, elig} >> rr_ptr);

    // Round-robin pick: lowest rotated offset wins, mapped back to a lane index.
    always_comb begin
        logic [3:0] sum;
        sel_found = 1'b0;
        sel_idx   = '0;
        sum       = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                sel_found = 1'b1;
                sum       = {1'b0, rr_ptr} + 4'(k);
                sel_idx   = (sum >= LANES_W4) ? 3'(sum - LANES_W4) : 3'(sum);
            end
        end
    end

    // State register.
    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and in_ready; the packet length is bounded by our own count,
    // never by lane_ready, so strobe-to-ready lag in the lane cannot overrun.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                state_nxt = STREAM;
            end
            STREAM: begin
                in_ready = (beat_cnt < PKT_BEATS);
                if (in_valid && (beat_cnt == LAST_BEAT)) begin
                    state_nxt = CLOSE;
                end
            end
            CLOSE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Lane selection, beat counting and round-robin pointer advance.
    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            cur_lane <= '0;
            beat_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sel_found) begin
                        cur_lane <= sel_idx;
                    end
                end
                GRANT: begin
                    beat_cnt <= '0;
                end
                STREAM: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                CLOSE: begin
                    rr_ptr <= (int'(cur_lane) == NUM_LANES - 1) ? 3'd0 : cur_lane + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Registered beat and one-hot strobe: exactly one cycle from accept to lane.
    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            lane_en   <= '0;
            lane_data <= '0;
        end else begin
            lane_en <= '0;
            if (xfer) begin
                lane_en   <= cur_onehot;
                lane_data <= in_data;
            end
        end
    end

    // Busy tracking: set on CLOSE, clear on a registered rising edge of
    // lane_complt; set wins when both hit the same lane in one cycle.
    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            complt_q  <= '0;
            lane_busy <= '0;
        end else begin
            complt_q  <= lane_complt;
            lane_busy <= (lane_busy & ~complt_rise) | busy_set;
        end
    end

`ifdef BUS2ST_SCHED_PKT_CNT_EN
    logic [15:0] pkt_cnt_q;

    // Dispatched-packet counter, one increment per CLOSE, wraps at 16 bits.
    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            pkt_cnt_q <= '0;
        end else if (state == CLOSE) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`else
    assign pkt_cnt = 16'h0000;
`endif

endmodule
